// File: rtl/ahb_word_subordinate_if.sv
// AHB-Lite bus bundle shared by a manager and the word-memory subordinate.
interface ahb_if;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [3:0]  HWSTRB;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport subordinate (
    input  HSEL, HTRANS, HWRITE, HSIZE, HADDR, HWDATA, HWSTRB,
    output HRDATA, HREADY, HRESP
  );

  modport manager (
    output HSEL, HTRANS, HWRITE, HSIZE, HADDR, HWDATA, HWSTRB,
    input  HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_word_subordinate.sv
// AHB-Lite subordinate serving single word transfers from local memory with programmable wait states.
// Define AHB_SUB_ERR_EN to answer out-of-range, misaligned or non-word transfers with ERROR.
module ahb_word_subordinate #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic        clk,
  input logic        reset,
  ahb_if.subordinate ahb
);
  localparam int unsigned AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          write_q, write_d;
  logic [31:0]   mem_q [MEM_WORDS];

  logic [31:0]   offset_s;
  logic [AW-1:0] idx_s;
  logic          err_s;
  logic          accept_s;
  logic          done_s;
  logic          hready_s;
  logic          hresp_s;
  logic [31:0]   hrdata_s;
  logic          unused_s;

  // Dropping the upper offset bits makes addresses wrap when error checking is off.
  assign offset_s = ahb.HADDR - BASE_ADDR;
  assign idx_s    = offset_s[AW+1:2];
  assign unused_s = ^{ahb.HSIZE, offset_s[1:0], offset_s[31:AW+2]};

`ifdef AHB_SUB_ERR_EN
  assign err_s = (ahb.HADDR < BASE_ADDR) ||
                 (offset_s[31:2] >= 30'(MEM_WORDS)) ||
                 (ahb.HADDR[1:0] != 2'b00) ||
                 (ahb.HSIZE != 3'b010);
`else
  assign err_s = 1'b0;
`endif

  assign done_s   = (state_q == S_DATA) && (cnt_q == 4'd0);
  assign accept_s = ahb.HSEL && ahb.HTRANS[1] && hready_s;

  // Response decode from the current state.
  always_comb begin
    hready_s = 1'b1;
    hresp_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        hready_s = 1'b1;
        hresp_s  = 1'b0;
      end
      S_DATA: hready_s = (cnt_q == 4'd0);
      S_ERR1: begin
        hready_s = 1'b0;
        hresp_s  = 1'b1;
      end
      S_ERR2: hresp_s = 1'b1;
      default: begin
        hready_s = 1'b1;
        hresp_s  = 1'b0;
      end
    endcase
  end

  // Next-state logic; an accepted address phase overrides the default successor.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    case (state_q)
      S_DATA: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    if (accept_s) begin
      idx_d   = idx_s;
      write_d = ahb.HWRITE;
      if (err_s) begin
        state_d = S_ERR1;
        cnt_d   = 4'd0;
      end else begin
        state_d = S_DATA;
        cnt_d   = 4'(WAIT_STATES);
      end
    end else begin
      idx_d   = idx_q;
      write_d = write_q;
    end
  end

  // Control registers; reset aborts any pending data phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
    end
  end

  // Byte-lane writes in the completing cycle only; memory keeps its contents over reset.
  always_ff @(posedge clk) begin
    if (done_s && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (ahb.HWSTRB[i]) begin
          mem_q[idx_q][8*i +: 8] <= ahb.HWDATA[8*i +: 8];
        end
      end
    end
  end

  // Read data is driven only while a read data phase completes.
  always_comb begin
    if (done_s && !write_q) begin
      hrdata_s = mem_q[idx_q];
    end else begin
      hrdata_s = 32'd0;
    end
  end

  assign ahb.HRDATA = hrdata_s;
  assign ahb.HREADY = hready_s;
`ifdef AHB_SUB_ERR_EN
  assign ahb.HRESP  = hresp_s;
`else
  assign ahb.HRESP  = 1'b0 & hresp_s;
`endif

endmodule

// File: tb/tb_ahb_word_subordinate.sv
// Directed bench: three subordinates (WAIT_STATES 1, 0, 3) on separate buses driven from one stimulus set.
module tb_ahb_word_subordinate;
  logic        clk = 1'b0;
  logic        reset;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [3:0]  hwstrb;
  int          tgt;

  logic [31:0] rdata_o;
  logic        ready_o;
  logic        resp_o;

  int          tests = 0;
  int          fails = 0;

  logic [31:0] rd;
  int          waits;
  logic        rf;
  logic        rl;
  int          streak;
  logic        wr;

  ahb_if bus0();
  ahb_if bus1();
  ahb_if bus3();

  assign bus0.HSEL = hsel && (tgt == 0);
  assign bus1.HSEL = hsel && (tgt == 1);
  assign bus3.HSEL = hsel && (tgt == 3);
  assign {bus0.HTRANS, bus0.HWRITE, bus0.HSIZE, bus0.HADDR, bus0.HWDATA, bus0.HWSTRB} = {htrans, hwrite, hsize, haddr, hwdata, hwstrb};
  assign {bus1.HTRANS, bus1.HWRITE, bus1.HSIZE, bus1.HADDR, bus1.HWDATA, bus1.HWSTRB} = {htrans, hwrite, hsize, haddr, hwdata, hwstrb};
  assign {bus3.HTRANS, bus3.HWRITE, bus3.HSIZE, bus3.HADDR, bus3.HWDATA, bus3.HWSTRB} = {htrans, hwrite, hsize, haddr, hwdata, hwstrb};

  ahb_word_subordinate #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (.clk(clk), .reset(reset), .ahb(bus0));
  ahb_word_subordinate #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1)) dut1 (.clk(clk), .reset(reset), .ahb(bus1));
  ahb_word_subordinate #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (.clk(clk), .reset(reset), .ahb(bus3));

  always #5 clk = ~clk;

  always_comb begin
    case (tgt)
      0:       {rdata_o, ready_o, resp_o} = {bus0.HRDATA, bus0.HREADY, bus0.HRESP};
      3:       {rdata_o, ready_o, resp_o} = {bus3.HRDATA, bus3.HREADY, bus3.HRESP};
      default: {rdata_o, ready_o, resp_o} = {bus1.HRDATA, bus1.HREADY, bus1.HRESP};
    endcase
  end

  function automatic logic [31:0] pat(input int i);
    return {8'(i), 8'hA5, 8'(~i), 8'(i * 3)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One NONSEQ transfer; write data is wrong during wait cycles and correct only in the completing cycle.
  task automatic xfer(input logic w, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] strb,
                      output logic [31:0] rdo, output int nw, output logic r_first, output logic r_last);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = w; haddr = addr; hsize = 3'b010;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = ~wd; hwstrb = strb;
    nw = 0;
    @(negedge clk);
    r_first = resp_o;
    while (!ready_o && nw < 20) begin
      nw++;
      @(negedge clk);
    end
    hwdata  = wd;
    rdo     = rdata_o;
    r_last  = resp_o;
    @(posedge clk); #1;
    hwdata = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010;
    haddr = 32'd0; hwdata = 32'd0; hwstrb = 4'h0; tgt = 1;

    // Reset state, then release with an idle bus.
    @(negedge clk);
    check("rst_hready", {31'd0, ready_o}, 32'd1);
    check("rst_hresp",  {31'd0, resp_o},  32'd0);
    check("rst_hrdata", rdata_o,          32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_hready", {31'd0, ready_o}, 32'd1);
    check("rel_hresp",  {31'd0, resp_o},  32'd0);
    check("rel_hrdata", rdata_o,          32'd0);

    // WAIT_STATES=1: full-word write/read and a strobed partial write.
    xfer(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, rd, waits, rf, rl);
    check("wr1_waits", 32'(waits), 32'd1);
    check("wr1_hrdata0", rd, 32'd0);
    check("wr1_resp", {31'd0, rl}, 32'd0);
    xfer(1'b0, 32'h40, 32'h0, 4'h0, rd, waits, rf, rl);
    check("rd1_waits", 32'(waits), 32'd1);
    check("rd1_data", rd, 32'hDEADBEEF);
    xfer(1'b1, 32'h40, 32'h11223344, 4'b0101, rd, waits, rf, rl);
    check("wr2_waits", 32'(waits), 32'd1);
    xfer(1'b0, 32'h40, 32'h0, 4'h0, rd, waits, rf, rl);
    check("rd2_strobe", rd, 32'hDE22BE44);
    @(negedge clk);
    check("idle_hrdata0", rdata_o, 32'd0);

`ifdef AHB_SUB_ERR_EN
    // Out-of-range read gets the two-cycle ERROR response.
    xfer(1'b0, 32'h1000, 32'h0, 4'h0, rd, waits, rf, rl);
    check("err_cycle1_hready_low", 32'(waits), 32'd1);
    check("err_cycle1_hresp", {31'd0, rf}, 32'd1);
    check("err_cycle2_hresp", {31'd0, rl}, 32'd1);
    check("err_hrdata0", rd, 32'd0);
`else
    // Without error checking the address wraps onto word 0.
    xfer(1'b1, 32'h0, 32'h0BADF00D, 4'hF, rd, waits, rf, rl);
    xfer(1'b0, 32'h1000, 32'h0, 4'h0, rd, waits, rf, rl);
    check("wrap_data", rd, 32'h0BADF00D);
    check("wrap_resp", {31'd0, rl}, 32'd0);
`endif
    xfer(1'b0, 32'h40, 32'h0, 4'h0, rd, waits, rf, rl);
    check("after_err_data", rd, 32'hDE22BE44);
    check("after_err_resp", {31'd0, rl}, 32'd0);

    // WAIT_STATES=0: 16 pipelined writes then 16 pipelined reads.
    tgt = 0;
    for (int p = 0; p < 2; p++) begin
      wr = (p == 0);
      streak = 0;
      @(posedge clk); #1;
      for (int i = 0; i <= 16; i++) begin
        if (i < 16) begin
          hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = 32'(i * 4);
        end else begin
          hsel = 1'b0; htrans = 2'b00;
        end
        if (i > 0) begin
          hwdata = pat(i - 1);
        end
        hwstrb = 4'hF;
        @(negedge clk);
        if (i > 0) begin
          if (ready_o) streak++;
          if (!wr) check($sformatf("burst_rd_%0d", i - 1), rdata_o, pat(i - 1));
        end
        @(posedge clk); #1;
      end
      check(wr ? "burst_wr_hready" : "burst_rd_hready", 32'(streak), 32'd16);
    end

    // WAIT_STATES=3: reset in the second wait cycle aborts the write.
    tgt = 3;
    xfer(1'b1, 32'h80, 32'h12345678, 4'hF, rd, waits, rf, rl);
    check("w3_waits", 32'(waits), 32'd3);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h80;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hCAFEF00D; hwstrb = 4'hF;
    @(negedge clk);
    check("w3_wait1_hready", {31'd0, ready_o}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("w3_rst_hready", {31'd0, ready_o}, 32'd1);
    check("w3_rst_hresp",  {31'd0, resp_o},  32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    xfer(1'b0, 32'h80, 32'h0, 4'h0, rd, waits, rf, rl);
    check("w3_old_data", rd, 32'h12345678);
    check("w3_rd_waits", 32'(waits), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
